// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin arbiter that feeds one APB master from N sources.
// The winner's packed word {addr, wdata, sel} and write flag are captured into an
// output register and held on a valid/ready handshake until the master accepts.
// Optional build macro ARB_LOCK_EN: a locking requester keeps the grant while
// it stays valid.
module apb_req_arbiter #(
    parameter int N  = 4,
    parameter int DW = 22,
    parameter int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_valid,
    input  logic [N*DW-1:0] req_data,
    input  logic [N-1:0]    req_write,
    input  logic [N-1:0]    req_lock,
    output logic [N-1:0]    req_ready,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [3:0]      m_addr,
    output logic [15:0]     m_wdata,
    output logic [1:0]      m_sel,
    output logic            m_write,
    output logic [IW-1:0]   m_grant_id,
    output logic            busy
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t          state_q;
    state_t          state_d;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   rr_idx;
    logic            rr_found;
    logic [IW-1:0]   win_idx;
    logic            win_found;
    logic            adv_ptr;
    logic            capture;
    logic [IW:0]     ptr_inc;
    logic [IW-1:0]   ptr_next;
    logic [DW-1:0]   win_word;

    // Round-robin search: first valid requester starting at ptr, wrapping at N.
    always_comb begin
        logic [IW:0] cand;
        rr_idx   = '0;
        rr_found = 1'b0;
        cand     = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(k);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!rr_found && req_valid[cand[IW-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = cand[IW-1:0];
            end
        end
    end

`ifdef ARB_LOCK_EN
    logic lock_q;
    logic lock_hit;

    assign lock_hit  = lock_q & req_valid[m_grant_id];
    assign win_idx   = lock_hit ? m_grant_id : rr_idx;
    assign win_found = lock_hit | rr_found;
    assign adv_ptr   = ~lock_hit;

    // Lock flag: loaded from the winner at capture, dropped when the locked source goes idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q <= 1'b0;
        end else if (capture) begin
            lock_q <= req_lock[win_idx];
        end else if (state_q == IDLE && lock_q && !req_valid[m_grant_id]) begin
            lock_q <= 1'b0;
        end
    end
`else
    logic unused_lock;

    assign unused_lock = ^req_lock;
    assign win_idx     = rr_idx;
    assign win_found   = rr_found;
    assign adv_ptr     = 1'b1;
`endif

    assign capture   = (state_q == IDLE) && win_found && !rst;
    assign req_ready = capture ? ({{(N-1){1'b0}}, 1'b1} << win_idx) : '0;
    assign win_word  = req_data[win_idx*DW +: DW];
    assign ptr_inc   = {1'b0, win_idx} + 1'b1;
    assign ptr_next  = (ptr_inc >= (IW+1)'(N)) ? '0 : ptr_inc[IW-1:0];
    assign m_valid   = (state_q == HOLD);
    assign busy      = (state_q == HOLD);

    // Next-state logic: IDLE captures any valid request, HOLD waits for the master.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_found) state_d = HOLD;
            HOLD:    if (m_ready)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output word register and pointer; data is kept after the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_sel      <= '0;
            m_write    <= 1'b0;
            m_grant_id <= '0;
        end else if (capture) begin
            m_addr     <= win_word[21:18];
            m_wdata    <= win_word[17:2];
            m_sel      <= win_word[1:0];
            m_write    <= req_write[win_idx];
            m_grant_id <= win_idx;
            if (adv_ptr) begin
                ptr_q <= ptr_next;
            end
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter (N=4). Lock scenarios run when ARB_LOCK_EN is defined.
module tb_apb_req_arbiter;

    localparam int N  = 4;
    localparam int DW = 22;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_write;
    logic [N-1:0]    req_lock;
    logic [N-1:0]    req_ready;
    logic            m_valid;
    logic            m_ready;
    logic [3:0]      m_addr;
    logic [15:0]     m_wdata;
    logic [1:0]      m_sel;
    logic            m_write;
    logic [IW-1:0]   m_grant_id;
    logic            busy;

    int checks = 0;
    int errors = 0;

    logic [3:0]  e_addr  [N];
    logic [15:0] e_wdata [N];
    logic [1:0]  e_sel   [N];
    logic        e_write [N];

    apb_req_arbiter #(.N(N), .DW(DW), .IW(IW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_write(req_write), .req_lock(req_lock),
        .req_ready(req_ready),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_sel(m_sel), .m_write(m_write),
        .m_grant_id(m_grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_word(input string tag, input int i);
        check({tag, " valid"}, 32'(m_valid), 32'd1);
        check({tag, " gid"},   32'(m_grant_id), 32'(i));
        check({tag, " addr"},  32'(m_addr), 32'(e_addr[i]));
        check({tag, " wdata"}, 32'(m_wdata), 32'(e_wdata[i]));
        check({tag, " sel"},   32'(m_sel), 32'(e_sel[i]));
        check({tag, " write"}, 32'(m_write), 32'(e_write[i]));
    endtask

    initial begin
        int pulses [N];
        int g;

        // Per-requester words built from independent constants.
        e_addr[0] = 4'h3; e_wdata[0] = 16'h1234; e_sel[0] = 2'b00; e_write[0] = 1'b0;
        e_addr[1] = 4'h5; e_wdata[1] = 16'hBEEF; e_sel[1] = 2'b01; e_write[1] = 1'b1;
        e_addr[2] = 4'h9; e_wdata[2] = 16'h0F0F; e_sel[2] = 2'b10; e_write[2] = 1'b0;
        e_addr[3] = 4'hC; e_wdata[3] = 16'hCAFE; e_sel[3] = 2'b11; e_write[3] = 1'b1;
        for (int i = 0; i < N; i++) begin
            req_data[i*DW +: DW] = {e_addr[i], e_wdata[i], e_sel[i]};
            req_write[i]         = e_write[i];
        end
        req_lock  = '0;
        m_ready   = 1'b0;
        req_valid = 4'b1111;
        rst       = 1'b1;

        // Reset held three cycles with every requester valid.
        for (int c = 0; c < 3; c++) begin
            step();
            check("rst req_ready", 32'(req_ready), 32'd0);
            check("rst m_valid",   32'(m_valid), 32'd0);
            check("rst busy",      32'(busy), 32'd0);
        end
        check("rst addr",  32'(m_addr), 32'd0);
        check("rst wdata", 32'(m_wdata), 32'd0);
        check("rst sel",   32'(m_sel), 32'd0);
        check("rst write", 32'(m_write), 32'd0);
        check("rst gid",   32'(m_grant_id), 32'd0);

        // First grant after release goes to requester 0.
        rst = 1'b0;
        #1;
        check("first req_ready", 32'(req_ready), 32'b0001);
        step();
        check_word("first", 0);
        check("first busy", 32'(busy), 32'd1);

        // Backpressure: ten cycles with m_ready low.
        for (int c = 0; c < 10; c++) begin
            step();
            check("bp req_ready", 32'(req_ready), 32'd0);
            check_word("bp", 0);
        end
        m_ready = 1'b1;
        #1;
        check("bp release req_ready", 32'(req_ready), 32'd0);
        step();
        check("bp done m_valid", 32'(m_valid), 32'd0);
        check("bp kept wdata", 32'(m_wdata), 32'(e_wdata[0]));
        check("bp next req_ready", 32'(req_ready), 32'b0010);

        // Fairness: all valid, m_ready high; grants 1,2,3,0,1,2 with a bubble between.
        for (int i = 0; i < N; i++) pulses[i] = 0;
        for (int i = 0; i < 12; i++) begin
            g = (1 + i / 2) % N;
            if (i < 8) begin
                for (int b = 0; b < N; b++) if (req_ready[b]) pulses[b]++;
            end
            if (i % 2 == 0) begin
                check("fair req_ready", 32'(req_ready), 32'(1) << g);
                check("fair idle m_valid", 32'(m_valid), 32'd0);
            end else begin
                check("fair hold req_ready", 32'(req_ready), 32'd0);
                check_word("fair", g);
            end
            step();
        end
        for (int b = 0; b < N; b++) check("fair pulses", 32'(pulses[b]), 32'd1);

        // Mid-HOLD reset: grant 3 (ptr wrapped), then reset while held.
        m_ready = 1'b0;
        #1;
        check("pre-rst req_ready", 32'(req_ready), 32'b1000);
        step();
        check_word("pre-rst", 3);
        rst = 1'b1;
        #1;
        check("midrst req_ready", 32'(req_ready), 32'd0);
        step();
        check("midrst m_valid", 32'(m_valid), 32'd0);
        check("midrst gid",     32'(m_grant_id), 32'd0);
        check("midrst addr",    32'(m_addr), 32'd0);
        rst = 1'b0;
        #1;
        check("midrst ptr0", 32'(req_ready), 32'b0001);
        step();
        check_word("midrst regrant", 0);

        // m_ready in IDLE with nothing valid has no effect.
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = '0;
        m_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check("idle m_valid", 32'(m_valid), 32'd0);
            check("idle req_ready", 32'(req_ready), 32'd0);
        end

        // Single requester 2 with word 22'h2ABCD5.
        req_data[2*DW +: DW] = 22'h2ABCD5;
        req_valid = 4'b0100;
        #1;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin
                check("single req_ready", 32'(req_ready), 32'b0100);
            end else begin
                check("single req_ready hold", 32'(req_ready), 32'd0);
                check("single m_valid", 32'(m_valid), 32'd1);
                check("single addr",  32'(m_addr), 32'hA);
                check("single wdata", 32'(m_wdata), 32'hAF35);
                check("single sel",   32'(m_sel), 32'b01);
                check("single gid",   32'(m_grant_id), 32'd2);
            end
            step();
        end
        req_data[2*DW +: DW] = {e_addr[2], e_wdata[2], e_sel[2]};

`ifdef ARB_LOCK_EN
        // Lock: requester 1 locks against requester 3.
        rst = 1'b1;
        req_valid = '0;
        step();
        rst = 1'b0;
        req_valid = 4'b1010;
        req_lock  = 4'b0010;
        m_ready   = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("lock req_ready", 32'(req_ready), 32'b0010);
            step();
            check_word("lock", 1);
            if (i == 2) req_valid = 4'b1000;
            step();
        end
        check("unlock req_ready", 32'(req_ready), 32'b1000);
        step();
        check_word("unlock", 3);
        req_valid = 4'b1010;
        step();
        check("after unlock req_ready", 32'(req_ready), 32'b0010);
        req_lock  = '0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

endmodule
